// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH / EXECUTE / WRITEBACK sequencing over
// internal program memory and register file, with load, debug and retire ports.
module multicycle_core #(
  parameter int              XLEN       = 32,
  parameter int              NREGS      = 32,
  parameter int              PMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          run_i,
  input  logic                          load_en_i,
  input  logic [$clog2(PMEM_DEPTH)-1:0] load_addr_i,
  input  logic [31:0]                   load_data_i,
  input  logic [4:0]                    dbg_addr_i,
  output logic [XLEN-1:0]               dbg_data_o,
  output logic [XLEN-1:0]               pc_o,
  output logic [31:0]                   instruction_o,
  output logic                          halted_o,
  output logic                          illegal_o,
  output logic [31:0]                   retired_o
);
  localparam int              AW      = $clog2(PMEM_DEPTH);
  localparam int              SHW     = $clog2(XLEN);
  localparam int              RW      = $clog2(NREGS);
  localparam logic [5:0]      NREGS6  = 6'(NREGS);
  localparam logic [XLEN-1:0] PC_MASK = XLEN'(PMEM_DEPTH * 4 - 1);

  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, next_pc_q, result_q;
  logic [31:0]     instr_q, retired_q;
  logic            illegal_q, wr_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [31:0]     pmem_q [PMEM_DEPTH];

  logic fetch_en, exec_en, wb_en, load_ok;

  function automatic logic idx_ok(input logic [4:0] a);
    return {1'b0, a} < NREGS6;
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
    if (a == 5'd0 || !idx_ok(a)) return '0;
    return regs_q[a[RW-1:0]];
  endfunction

  logic [6:0]      opcode, funct7, sh_f7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] op_a, op_b, imm_i, imm_u, br_tgt, jal_tgt, pc_plus4;

  assign opcode   = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign funct7   = instr_q[31:25];
  // Bit 25 is shamt[5] on wider datapaths; on XLEN=32 it must be zero.
  assign sh_f7    = {instr_q[31:26], (XLEN == 32) ? instr_q[25] : 1'b0};
  assign op_a     = rf_read(rs1);
  assign op_b     = rf_read(rs2);
  assign imm_i    = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_u    = {{(XLEN-32){instr_q[31]}}, instr_q[31:12], 12'b0};
  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_tgt   = pc_q + {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                            instr_q[30:25], instr_q[11:8], 1'b0};
  assign jal_tgt  = pc_q + {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                            instr_q[20], instr_q[30:21], 1'b0};

  logic            ex_illegal, ex_break, ex_wr, taken;
  logic [XLEN-1:0] ex_res, ex_npc;

  always_comb begin
    ex_illegal = 1'b0;
    ex_break   = 1'b0;
    ex_wr      = 1'b0;
    taken      = 1'b0;
    ex_res     = '0;
    ex_npc     = pc_plus4;
    case (opcode)
      OPC_OPIMM: begin
        ex_wr      = 1'b1;
        ex_illegal = !idx_ok(rd) || !idx_ok(rs1);
        case (funct3)
          3'd0: ex_res = op_a + imm_i;
          3'd1: begin
            ex_res = op_a << imm_i[SHW-1:0];
            if (sh_f7 != 7'h00) ex_illegal = 1'b1;
          end
          3'd2: ex_res = XLEN'($signed(op_a) < $signed(imm_i));
          3'd3: ex_res = XLEN'(op_a < imm_i);
          3'd4: ex_res = op_a ^ imm_i;
          3'd6: ex_res = op_a | imm_i;
          3'd7: ex_res = op_a & imm_i;
          default: begin
            if (sh_f7 == 7'h00)      ex_res = op_a >> imm_i[SHW-1:0];
            else if (sh_f7 == 7'h20) ex_res = XLEN'($signed(op_a) >>> imm_i[SHW-1:0]);
            else                     ex_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        ex_wr      = 1'b1;
        ex_illegal = !idx_ok(rd) || !idx_ok(rs1) || !idx_ok(rs2);
        if (funct7 == 7'h20) begin
          if (funct3 == 3'd0)      ex_res = op_a - op_b;
          else if (funct3 == 3'd5) ex_res = XLEN'($signed(op_a) >>> op_b[SHW-1:0]);
          else                     ex_illegal = 1'b1;
        end else if (funct7 == 7'h00) begin
          case (funct3)
            3'd0:    ex_res = op_a + op_b;
            3'd1:    ex_res = op_a << op_b[SHW-1:0];
            3'd2:    ex_res = XLEN'($signed(op_a) < $signed(op_b));
            3'd3:    ex_res = XLEN'(op_a < op_b);
            3'd4:    ex_res = op_a ^ op_b;
            3'd5:    ex_res = op_a >> op_b[SHW-1:0];
            3'd6:    ex_res = op_a | op_b;
            default: ex_res = op_a & op_b;
          endcase
        end else begin
          ex_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        ex_wr      = 1'b1;
        ex_illegal = !idx_ok(rd);
        ex_res     = imm_u;
      end
      OPC_BRANCH: begin
        ex_illegal = !idx_ok(rs1) || !idx_ok(rs2);
        if (funct3 == 3'd0)      taken = (op_a == op_b);
        else if (funct3 == 3'd1) taken = (op_a != op_b);
        else                     ex_illegal = 1'b1;
        if (taken) begin
          ex_npc = br_tgt;
          if (br_tgt[1:0] != 2'b00) ex_illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        ex_wr      = 1'b1;
        ex_illegal = !idx_ok(rd) || (jal_tgt[1:0] != 2'b00);
        ex_res     = pc_plus4;
        ex_npc     = jal_tgt;
      end
      OPC_SYSTEM: begin
        if (instr_q == 32'h0010_0073) ex_break   = 1'b1;
        else                          ex_illegal = 1'b1;
      end
      default: ex_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run_i) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = (ex_illegal || ex_break) ? S_HALT : S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    fetch_en = 1'b0;
    exec_en  = 1'b0;
    wb_en    = 1'b0;
    load_ok  = 1'b0;
    halted_o = 1'b0;
    case (state_q)
      S_IDLE:  load_ok  = 1'b1;
      S_FETCH: fetch_en = 1'b1;
      S_EXEC:  exec_en  = 1'b1;
      S_WB:    wb_en    = 1'b1;
      default: begin
        load_ok  = 1'b1;
        halted_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      next_pc_q <= '0;
      result_q  <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (fetch_en) instr_q <= pmem_q[pc_q[AW+1:2]];
      if (exec_en) begin
        result_q  <= ex_res;
        next_pc_q <= ex_npc & PC_MASK;
        wr_q      <= ex_wr && (rd != 5'd0);
        if (ex_illegal) illegal_q <= 1'b1;
      end
      if (wb_en) begin
        pc_q      <= next_pc_q;
        retired_q <= retired_q + 32'd1;
        if (wr_q) regs_q[rd[RW-1:0]] <= result_q;
      end
    end
  end

  // Program memory survives reset so a loaded program can be rerun.
  always_ff @(posedge clk_i) begin
    if (load_en_i && load_ok) pmem_q[load_addr_i] <= load_data_i;
  end

  assign dbg_data_o    = rf_read(dbg_addr_i);
  assign pc_o          = pc_q;
  assign instruction_o = instr_q;
  assign illegal_o     = illegal_q;
  assign retired_o     = retired_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small hand-assembled programs with
// hand-computed register, pc, retire and halt expectations.
module tb_multicycle_core;
  logic        clk_i = 1'b0;
  logic        rst_ni, run_i, load_en_i;
  logic [5:0]  load_addr_i;
  logic [31:0] load_data_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_o, pc_o, instruction_o, retired_o;
  logic        halted_o, illegal_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  multicycle_core dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i),
    .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o), .pc_o(pc_o),
    .instruction_o(instruction_o), .halted_o(halted_o), .illegal_o(illegal_o),
    .retired_o(retired_o)
  );

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
    dbg_addr_i = 5'(r);
    #1;
    chk(tag, dbg_data_o, exp);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; run_i = 1'b0; load_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_addr_i = 6'(a);
    load_data_i = d;
    load_en_i   = 1'b1;
    @(negedge clk_i);
    load_en_i   = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    int k;
    k = 0;
    run_i = 1'b1;
    while (!halted_o && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    run_i = 1'b0;
    chk({tag, "_halted"}, {31'b0, halted_o}, 32'd1);
  endtask

  logic [31:0] exp1 [5] = '{32'd120, 32'd200, 32'd2200, 32'd0, 32'd10};
  int          r2   [15] = '{29, 31, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17};
  logic [31:0] e2   [15] = '{32'd2, 32'd5, 32'd7, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF,
                             32'd1, 32'd2, 32'd40, 32'hF, 32'd1, 32'hABCD_E000,
                             32'h3FFF_FFFF, 32'hFFFF_FFFE, 32'd5};
  logic [31:0] bad  [5];

  initial begin
    rst_ni = 1'b0; run_i = 1'b0; load_en_i = 1'b0;
    load_addr_i = '0; load_data_i = '0; dbg_addr_i = 5'd5;
    repeat (2) @(negedge clk_i);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_instr", instruction_o, 32'd0);
    chk("rst_halted", {31'b0, halted_o}, 32'd0);
    chk("rst_illegal", {31'b0, illegal_o}, 32'd0);
    chk("rst_retired", retired_o, 32'd0);
    chk("rst_x5", dbg_data_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Program 1: x5 trace at every retire
    load(0, i_t(12'd120, 5'd0, 3'd0, 5'd5));
    load(1, i_t(12'd200, 5'd0, 3'd0, 5'd5));
    load(2, i_t(12'd2000, 5'd5, 3'd0, 5'd5));
    load(3, i_t(12'hFFF, 5'd0, 3'd7, 5'd5));
    load(4, i_t(12'd10, 5'd0, 3'd6, 5'd5));
    load(5, EBREAK);
    dbg_addr_i = 5'd5;
    run_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int k;
      k = 0;
      while (retired_o != 32'(i + 1) && k < 12) begin
        @(negedge clk_i);
        k++;
      end
      chk($sformatf("p1_retire%0d", i), retired_o, 32'(i + 1));
      chk($sformatf("p1_x5_%0d", i), dbg_data_o, exp1[i]);
    end
    run_to_halt("p1");
    chk("p1_illegal", {31'b0, illegal_o}, 32'd0);
    chk("p1_retired", retired_o, 32'd5);
    chk("p1_pc", pc_o, 32'd20);

    // Program 2: ALU coverage
    do_reset();
    load(0,  i_t(12'd2, 5'd0, 3'd0, 5'd29));
    load(1,  i_t(12'd5, 5'd0, 3'd0, 5'd31));
    load(2,  r_t(7'h00, 5'd29, 5'd31, 3'd0, 5'd5));
    load(3,  r_t(7'h20, 5'd31, 5'd29, 3'd0, 5'd6));
    load(4,  r_t(7'h00, 5'd0, 5'd6, 3'd2, 5'd7));
    load(5,  r_t(7'h20, 5'd29, 5'd6, 3'd5, 5'd8));
    load(6,  r_t(7'h00, 5'd6, 5'd0, 3'd3, 5'd9));
    load(7,  i_t(12'hFFF, 5'd6, 3'd4, 5'd10));
    load(8,  i_t(12'd3, 5'd31, 3'd1, 5'd11));
    load(9,  i_t(12'd28, 5'd6, 3'd5, 5'd12));
    load(10, i_t(12'hFFF, 5'd31, 3'd3, 5'd13));
    load(11, {20'hABCDE, 5'd14, 7'h37});
    load(12, r_t(7'h00, 5'd29, 5'd6, 3'd5, 5'd15));
    load(13, i_t(12'h401, 5'd6, 3'd5, 5'd16));
    load(14, r_t(7'h00, 5'd31, 5'd6, 3'd7, 5'd17));
    load(15, EBREAK);
    run_to_halt("p2");
    for (int i = 0; i < 15; i++) chk_reg($sformatf("p2_x%0d", r2[i]), r2[i], e2[i]);
    chk("p2_retired", retired_o, 32'd15);
    chk("p2_pc", pc_o, 32'd60);

    // Program 3: countdown loop
    do_reset();
    load(0, i_t(12'd3, 5'd0, 3'd0, 5'd1));
    load(1, i_t(12'hFFF, 5'd1, 3'd0, 5'd1));
    load(2, b_t(13'h1FFC, 5'd0, 5'd1, 3'd1));
    load(3, EBREAK);
    run_to_halt("p3");
    chk_reg("p3_x1", 1, 32'd0);
    chk("p3_retired", retired_o, 32'd7);
    chk("p3_pc", pc_o, 32'd12);

    // Program 4: JAL with link and with x0
    do_reset();
    load(0, j_t(21'd8, 5'd1));
    load(1, i_t(12'd1, 5'd0, 3'd0, 5'd2));
    load(2, j_t(21'd8, 5'd0));
    load(3, i_t(12'd1, 5'd0, 3'd0, 5'd3));
    load(4, EBREAK);
    run_to_halt("p4");
    chk_reg("p4_x1", 1, 32'd4);
    chk_reg("p4_x2", 2, 32'd0);
    chk_reg("p4_x3", 3, 32'd0);
    chk_reg("p4_x0", 0, 32'd0);
    chk("p4_pc", pc_o, 32'd16);
    chk("p4_retired", retired_o, 32'd2);

    // Misaligned target on a branch that is not taken is harmless
    do_reset();
    load(0, b_t(13'd6, 5'd0, 5'd0, 3'd1));
    load(1, EBREAK);
    run_to_halt("p5");
    chk("p5_illegal", {31'b0, illegal_o}, 32'd0);
    chk("p5_retired", retired_o, 32'd1);
    chk("p5_pc", pc_o, 32'd4);

    // All-ones word: exact halt timing, then loads while halted
    do_reset();
    load(0, 32'hFFFF_FFFF);
    run_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("ill_not_yet_halted", {31'b0, halted_o}, 32'd0);
    @(negedge clk_i);
    run_i = 1'b0;
    chk("ill_halted", {31'b0, halted_o}, 32'd1);
    chk("ill_illegal", {31'b0, illegal_o}, 32'd1);
    chk("ill_retired", retired_o, 32'd0);
    chk("ill_instr", instruction_o, 32'hFFFF_FFFF);
    chk("ill_pc", pc_o, 32'd0);
    load(0, i_t(12'd77, 5'd0, 3'd0, 5'd5));
    load(1, EBREAK);
    repeat (3) @(negedge clk_i);
    chk("ill_still_halted", {31'b0, halted_o}, 32'd1);
    chk("ill_still_pc", pc_o, 32'd0);
    do_reset();
    run_to_halt("hload");
    chk_reg("hload_x5", 5, 32'd77);
    chk("hload_illegal", {31'b0, illegal_o}, 32'd0);

    // Further illegal encodings
    bad[0] = i_t(12'h020, 5'd0, 3'd1, 5'd5);
    bad[1] = r_t(7'h20, 5'd2, 5'd1, 3'd6, 5'd3);
    bad[2] = b_t(13'd6, 5'd0, 5'd0, 3'd0);
    bad[3] = 32'h0000_0073;
    bad[4] = b_t(13'd8, 5'd0, 5'd0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      do_reset();
      load(0, bad[i]);
      load(1, EBREAK);
      run_to_halt($sformatf("bad%0d", i));
      chk($sformatf("bad%0d_illegal", i), {31'b0, illegal_o}, 32'd1);
      chk($sformatf("bad%0d_retired", i), retired_o, 32'd0);
      chk($sformatf("bad%0d_pc", i), pc_o, 32'd0);
    end

    // Reset during EXECUTE aborts the instruction
    do_reset();
    load(0, i_t(12'd9, 5'd0, 3'd0, 5'd5));
    load(1, EBREAK);
    run_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    run_i  = 1'b0;
    #1;
    chk_reg("abort_x5", 5, 32'd0);
    chk("abort_pc", pc_o, 32'd0);
    chk("abort_instr", instruction_o, 32'd0);
    chk("abort_retired", retired_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("abort_idle_instr", instruction_o, 32'd0);
    chk("abort_idle_retired", retired_o, 32'd0);
    chk_reg("abort_idle_x5", 5, 32'd0);

    // Load pulsed in FETCH is ignored, then reset in EXECUTE
    run_i = 1'b1;
    @(negedge clk_i);
    load(0, i_t(12'd55, 5'd0, 3'd0, 5'd5));
    rst_ni = 1'b0;
    run_i  = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_to_halt("noload");
    chk_reg("noload_x5", 5, 32'd9);
    chk("noload_retired", retired_o, 32'd1);
    chk("noload_pc", pc_o, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
